// File: rtl/sent_rx_crc_check.sv
// SENT receive CRC checker: bit-serial CRC4/CRC6 over fast-channel frames and
// serial messages, with result registers, overrun flag and saturating error count.
module sent_rx_crc_check #(
    parameter logic [3:0]  CRC4_SEED = 4'h5,
    parameter logic [5:0]  CRC6_SEED = 6'h15,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk_rx,
    input  logic                 reset_rx,
    input  logic [29:0]          data_check_crc_i,
    input  logic [2:0]           done_pre_data_i,
    input  logic                 clear_cnt_i,
    output logic                 busy_o,
    output logic                 crc_valid_o,
    output logic                 crc_ok_o,
    output logic [2:0]           msg_type_o,
    output logic [23:0]          data_o,
    output logic [5:0]           crc_rx_o,
    output logic [5:0]           crc_calc_o,
    output logic [ERR_CNT_W-1:0] crc_err_cnt_o,
    output logic                 overrun_o
);

    localparam int unsigned DATA_W    = 30;
    localparam int unsigned PAY_W     = 24;
    localparam int unsigned CRC_W     = 6;
    localparam int unsigned CNT_W     = 5;
    localparam logic [3:0]  CRC4_POLY = 4'hD;   // x^3+x^2+1 (x^4 implicit)
    localparam logic [5:0]  CRC6_POLY = 6'h19;  // x^4+x^3+1 (x^6 implicit)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, next_state;
    logic               strobe_c;
    logic               load_c, shift_c, finish_c, drop_c;

    logic [DATA_W-1:0]  ld_shift_c;
    logic [PAY_W-1:0]   ld_payload_c;
    logic [CRC_W-1:0]   ld_rx_c;
    logic [CNT_W-1:0]   ld_n_c;
    logic               ld_wide_c;

    logic [2:0]         typ_q;
    logic [DATA_W-1:0]  sh_q;
    logic [PAY_W-1:0]   payload_q;
    logic [CRC_W-1:0]   rx_q;
    logic [CRC_W-1:0]   crc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wide_q;
    logic [CRC_W-1:0]   crc_nxt_c;
    logic [3:0]         crc4_nxt_c;

    assign strobe_c = (done_pre_data_i != 3'd0) && (done_pre_data_i <= 3'd5);

    // Field extraction per message type; shift image is payload MSB-aligned
    // with zero fill supplying the augmentation bits.
    always_comb begin
        ld_shift_c   = '0;
        ld_payload_c = '0;
        ld_rx_c      = '0;
        ld_n_c       = '0;
        ld_wide_c    = 1'b0;
        case (done_pre_data_i)
            3'd1: begin
                ld_payload_c = data_check_crc_i[27:4];
                ld_shift_c   = {data_check_crc_i[27:4], 6'b0};
                ld_rx_c      = {2'b0, data_check_crc_i[3:0]};
                ld_n_c       = CNT_W'(28);
            end
            3'd2: begin
                ld_payload_c = {8'b0, data_check_crc_i[19:4]};
                ld_shift_c   = {data_check_crc_i[19:4], 14'b0};
                ld_rx_c      = {2'b0, data_check_crc_i[3:0]};
                ld_n_c       = CNT_W'(20);
            end
            3'd3, 3'd4: begin
                ld_payload_c = {12'b0, data_check_crc_i[15:4]};
                ld_shift_c   = {data_check_crc_i[15:4], 18'b0};
                ld_rx_c      = {2'b0, data_check_crc_i[3:0]};
                ld_n_c       = CNT_W'(16);
            end
            3'd5: begin
                ld_payload_c = data_check_crc_i[29:6];
                ld_shift_c   = {data_check_crc_i[29:6], 6'b0};
                ld_rx_c      = data_check_crc_i[5:0];
                ld_n_c       = CNT_W'(30);
                ld_wide_c    = 1'b1;
            end
            default: ;
        endcase
    end

    // One serial CRC step on the current MSB of the shift image.
    always_comb begin
        crc4_nxt_c = {crc_q[2:0], sh_q[DATA_W-1]} ^ (crc_q[3] ? CRC4_POLY : 4'h0);
        if (wide_q) begin
            crc_nxt_c = {crc_q[4:0], sh_q[DATA_W-1]} ^ (crc_q[5] ? CRC6_POLY : 6'h0);
        end else begin
            crc_nxt_c = {2'b0, crc4_nxt_c};
        end
    end

    // State register.
    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode.
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        finish_c   = 1'b0;
        drop_c     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (strobe_c) begin
                    load_c     = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
                drop_c  = strobe_c;
                if (cnt_q == CNT_W'(1)) begin
                    finish_c   = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture on accept, then shift one bit per cycle.
    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            typ_q     <= '0;
            sh_q      <= '0;
            payload_q <= '0;
            rx_q      <= '0;
            crc_q     <= '0;
            cnt_q     <= '0;
            wide_q    <= 1'b0;
        end else if (load_c) begin
            typ_q     <= done_pre_data_i;
            sh_q      <= ld_shift_c;
            payload_q <= ld_payload_c;
            rx_q      <= ld_rx_c;
            crc_q     <= ld_wide_c ? CRC6_SEED : {2'b0, CRC4_SEED};
            cnt_q     <= ld_n_c;
            wide_q    <= ld_wide_c;
        end else if (shift_c) begin
            sh_q      <= {sh_q[DATA_W-2:0], 1'b0};
            crc_q     <= crc_nxt_c;
            cnt_q     <= cnt_q - CNT_W'(1);
        end
    end

    // Result, status strobes and held result fields.
    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            busy_o      <= 1'b0;
            crc_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
            crc_ok_o    <= 1'b0;
            msg_type_o  <= '0;
            data_o      <= '0;
            crc_rx_o    <= '0;
            crc_calc_o  <= '0;
        end else begin
            busy_o      <= (next_state == SHIFT);
            crc_valid_o <= finish_c;
            overrun_o   <= drop_c;
            if (finish_c) begin
                crc_ok_o   <= (crc_nxt_c == rx_q);
                msg_type_o <= typ_q;
                data_o     <= payload_q;
                crc_rx_o   <= rx_q;
                crc_calc_o <= crc_nxt_c;
            end
        end
    end

    // Saturating mismatch counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            crc_err_cnt_o <= '0;
        end else if (clear_cnt_i) begin
            crc_err_cnt_o <= '0;
        end else if (crc_valid_o && !crc_ok_o && (crc_err_cnt_o != '1)) begin
            crc_err_cnt_o <= crc_err_cnt_o + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sent_rx_crc_check.sv
// Self-checking bench for sent_rx_crc_check: vector table + scoreboard,
// plus hand sequences for overrun, saturation, clear priority and reset.
module tb_sent_rx_crc_check;

    logic        clk_rx = 1'b0;
    logic        reset_rx;
    logic [29:0] data_check_crc_i;
    logic [2:0]  done_pre_data_i;
    logic        clear_cnt_i;
    logic        busy_o, crc_valid_o, crc_ok_o, overrun_o;
    logic [2:0]  msg_type_o;
    logic [23:0] data_o;
    logic [5:0]  crc_rx_o, crc_calc_o;
    logic [7:0]  crc_err_cnt_o;

    sent_rx_crc_check dut (
        .clk_rx           (clk_rx),
        .reset_rx         (reset_rx),
        .data_check_crc_i (data_check_crc_i),
        .done_pre_data_i  (done_pre_data_i),
        .clear_cnt_i      (clear_cnt_i),
        .busy_o           (busy_o),
        .crc_valid_o      (crc_valid_o),
        .crc_ok_o         (crc_ok_o),
        .msg_type_o       (msg_type_o),
        .data_o           (data_o),
        .crc_rx_o         (crc_rx_o),
        .crc_calc_o       (crc_calc_o),
        .crc_err_cnt_o    (crc_err_cnt_o),
        .overrun_o        (overrun_o)
    );

    always #5 clk_rx = ~clk_rx;

    typedef struct {
        logic [2:0]  typ;
        logic [23:0] data;
        logic [5:0]  rx;
        logic [5:0]  calc;
        logic        ok;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  typ;
        logic [29:0] d;
        logic        ok;
        logic [5:0]  calc;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ovr_seen = 0;
    int   last_exp = 0;

    always @(posedge clk_rx) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [23:0] pay(input logic [2:0] t, input logic [29:0] d);
        case (t)
            3'd1:       return d[27:4];
            3'd2:       return {8'h0, d[19:4]};
            3'd3, 3'd4: return {12'h0, d[15:4]};
            default:    return d[29:6];
        endcase
    endfunction

    function automatic logic [5:0] rxf(input logic [2:0] t, input logic [29:0] d);
        return (t == 3'd5) ? d[5:0] : {2'b0, d[3:0]};
    endfunction

    function automatic int nbits(input logic [2:0] t);
        case (t)
            3'd1:       return 28;
            3'd2:       return 20;
            3'd3, 3'd4: return 16;
            default:    return 30;
        endcase
    endfunction

    // Reference: remainder of (seed*x^N + payload*x^w) by the full generator.
    function automatic logic [5:0] model(input logic [2:0] t, input logic [29:0] d);
        logic [63:0] v, poly;
        int w;
        w    = (t == 3'd5) ? 6 : 4;
        poly = (t == 3'd5) ? 64'h59 : 64'h1D;
        v    = ((t == 3'd5) ? 64'h15 : 64'h5) << nbits(t);
        v    = v ^ (64'(pay(t, d)) << w);
        for (int i = 63; i >= w; i--) begin
            if (v[i]) v = v ^ (poly << (i - w));
        end
        return v[5:0];
    endfunction

    function automatic vec_t mk(input logic [2:0] t, input logic [23:0] p, input logic good);
        vec_t r;
        logic [5:0] rx;
        case (t)
            3'd1:       r.d = {2'b0, p, 4'h0};
            3'd2:       r.d = {10'h0, p[15:0], 4'h0};
            3'd3, 3'd4: r.d = {14'h0, p[11:0], 4'h0};
            default:    r.d = {p, 6'h0};
        endcase
        r.typ  = t;
        r.calc = model(t, r.d);
        rx     = good ? r.calc : (r.calc ^ 6'h01);
        r.d    = r.d | 30'(rx);
        r.ok   = good;
        return r;
    endfunction

    // Result monitor: every valid must match the oldest expectation.
    always @(negedge clk_rx) begin
        exp_t e;
        if (overrun_o) ovr_seen++;
        if (crc_valid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid with empty scoreboard (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                chk("msg_type",    32'(msg_type_o), 32'(e.typ));
                chk("data",        32'(data_o),     32'(e.data));
                chk("crc_rx",      32'(crc_rx_o),   32'(e.rx));
                chk("crc_calc",    32'(crc_calc_o), 32'(e.calc));
                chk("crc_ok",      32'(crc_ok_o),   32'(e.ok));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk_rx);
            #1;
        end
    endtask

    task automatic push_exp(input logic [2:0] t, input logic [29:0] d,
                            input logic ok, input logic [5:0] calc);
        exp_t e;
        e.typ  = t;
        e.data = pay(t, d);
        e.rx   = rxf(t, d);
        e.calc = calc;
        e.ok   = ok;
        e.cyc  = cyc + nbits(t) + 1;
        sb.push_back(e);
        last_exp = e.cyc;
    endtask

    task automatic send_raw(input logic [2:0] t, input logic [29:0] d);
        done_pre_data_i  = t;
        data_check_crc_i = d;
        @(posedge clk_rx);
        #1;
        done_pre_data_i  = 3'd0;
    endtask

    task automatic send(input logic [2:0] t, input logic [29:0] d,
                        input logic ok, input logic [5:0] calc);
        push_exp(t, d, ok, calc);
        send_raw(t, d);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        int   n_bad, base, s;

        tbl[0] = '{3'd1, 30'h0000005, 1'b1, 6'h05};
        tbl[1] = '{3'd1, 30'h0000004, 1'b0, 6'h05};
        tbl[2] = '{3'd3, 30'h0000009, 1'b1, 6'h09};
        tbl[3] = '{3'd2, 30'h000000C, 1'b1, 6'h0C};
        tbl[4] = '{3'd5, 30'h0000026, 1'b1, 6'h26};
        tbl[5] = mk(3'd1, 24'hA5C3F1, 1'b1);
        tbl[6] = mk(3'd2, 24'h00BEEF, 1'b0);
        tbl[7] = mk(3'd4, 24'h000ABC, 1'b1);
        tbl[8] = mk(3'd5, 24'h3C5A96, 1'b1);
        tbl[9] = mk(3'd3, 24'h000123, 1'b0);

        reset_rx = 1'b1;
        done_pre_data_i = 3'd0;
        data_check_crc_i = '0;
        clear_cnt_i = 1'b0;
        repeat (3) @(posedge clk_rx);
        #1;
        @(negedge clk_rx);
        chk("rst_busy",     32'(busy_o),        0);
        chk("rst_valid",    32'(crc_valid_o),   0);
        chk("rst_ok",       32'(crc_ok_o),      0);
        chk("rst_type",     32'(msg_type_o),    0);
        chk("rst_data",     32'(data_o),        0);
        chk("rst_calc",     32'(crc_calc_o),    0);
        chk("rst_errcnt",   32'(crc_err_cnt_o), 0);
        chk("rst_overrun",  32'(overrun_o),     0);
        @(posedge clk_rx);
        #1;
        reset_rx = 1'b0;

        // Single good frame, then single bad frame.
        send(3'd1, 30'h0000005, 1'b1, 6'h05);
        wait_until(last_exp + 1);
        @(negedge clk_rx);
        chk("errcnt_after_good", 32'(crc_err_cnt_o), 0);
        chk("busy_after_done",   32'(busy_o), 0);
        @(posedge clk_rx);
        #1;
        send(3'd1, 30'h0000004, 1'b0, 6'h05);
        wait_until(last_exp + 1);
        @(negedge clk_rx);
        chk("errcnt_after_bad", 32'(crc_err_cnt_o), 1);
        @(posedge clk_rx);
        #1;

        // Table, every vector issued back-to-back on the previous DONE cycle.
        base  = ovr_seen;
        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) wait_until(last_exp);
            if (!tbl[i].ok) n_bad++;
            send(tbl[i].typ, tbl[i].d, tbl[i].ok, tbl[i].calc);
        end
        wait_until(last_exp + 1);
        @(negedge clk_rx);
        chk("b2b_no_overrun", 32'(ovr_seen - base), 0);
        chk("errcnt_table",   32'(crc_err_cnt_o), 32'(1 + n_bad));
        @(posedge clk_rx);
        #1;

        // Overrun: type 100, then type 001 five cycles later; 110 ignored.
        base = ovr_seen;
        s    = cyc;
        tbl[0] = mk(3'd4, 24'h0005A5, 1'b1);
        send(tbl[0].typ, tbl[0].d, 1'b1, tbl[0].calc);
        @(negedge clk_rx);
        chk("busy_first_shift", 32'(busy_o), 1);
        wait_until(s + 5);
        send_raw(3'd1, 30'h0000005);
        @(negedge clk_rx);
        chk("overrun_pulse", 32'(overrun_o), 1);
        wait_until(s + 7);
        @(negedge clk_rx);
        chk("overrun_one_cycle", 32'(overrun_o), 0);
        wait_until(s + 8);
        send_raw(3'd6, 30'h3FFFFFFF);
        @(negedge clk_rx);
        chk("ignored_code_no_overrun", 32'(overrun_o), 0);
        wait_until(last_exp + 1);
        @(negedge clk_rx);
        chk("overrun_total", 32'(ovr_seen - base), 1);
        chk("busy_idle",     32'(busy_o), 0);
        @(posedge clk_rx);
        #1;

        // Saturation over 300 back-to-back mismatches.
        clear_cnt_i = 1'b1;
        @(posedge clk_rx);
        #1;
        clear_cnt_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) wait_until(last_exp);
            send(3'd3, 30'h0, 1'b0, 6'h09);
            if (i == 254) begin
                wait_until(last_exp + 1);
                @(negedge clk_rx);
                chk("errcnt_at_255", 32'(crc_err_cnt_o), 32'hFF);
                @(posedge clk_rx);
                #1;
            end
        end
        wait_until(last_exp + 1);
        @(negedge clk_rx);
        chk("errcnt_saturated", 32'(crc_err_cnt_o), 32'hFF);
        @(posedge clk_rx);
        #1;

        // Clear coincident with a mismatch result.
        for (int k = 0; k < 3; k++) begin
            send(3'd3, 30'h0, 1'b0, 6'h09);
            wait_until(last_exp);
            clear_cnt_i = (k != 1);
            @(posedge clk_rx);
            #1;
            clear_cnt_i = 1'b0;
            @(negedge clk_rx);
            chk("errcnt_clear_priority", 32'(crc_err_cnt_o), (k == 1) ? 1 : 0);
            @(posedge clk_rx);
            #1;
        end

        // Reset mid-SHIFT with a coincident strobe; next strobe right after.
        send_raw(3'd1, 30'h0000005);
        repeat (10) begin
            @(posedge clk_rx);
            #1;
        end
        reset_rx = 1'b1;
        done_pre_data_i = 3'd2;
        data_check_crc_i = 30'h000000C;
        @(posedge clk_rx);
        #1;
        reset_rx = 1'b0;
        push_exp(3'd5, 30'h0000026, 1'b1, 6'h26);
        done_pre_data_i = 3'd5;
        data_check_crc_i = 30'h0000026;
        @(negedge clk_rx);
        chk("midrst_busy",  32'(busy_o),      0);
        chk("midrst_type",  32'(msg_type_o),  0);
        chk("midrst_calc",  32'(crc_calc_o),  0);
        chk("midrst_rx",    32'(crc_rx_o),    0);
        @(posedge clk_rx);
        #1;
        done_pre_data_i = 3'd0;
        wait_until(last_exp + 5);
        @(negedge clk_rx);
        chk("errcnt_after_reset", 32'(crc_err_cnt_o), 0);
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sent_rx_crc_check.md
SENT_RX_CRC_CHECK -- requirements
Module: sent_rx_crc_check

Interface
REQ-001 SHALL have parameter CRC4_SEED, 4'h5, seed for the 4-bit nibble CRC.
REQ-002 SHALL have parameter CRC6_SEED, 6'h15, seed for the 6-bit enhanced-serial CRC.
REQ-003 SHALL have parameter ERR_CNT_W, 8, width of the error counter.
REQ-004 SHALL have port clk_rx  in  1  rx clock; the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset_rx  in  1  synchronous, active-high reset.
REQ-006 SHALL have port data_check_crc_i  in  30  packed frame or message from the pulse decoder.
REQ-007 SHALL have port done_pre_data_i  in  3  one-cycle type strobe: 001 fast 6 nibbles, 010 fast 4 nibbles, 011 fast 3 nibbles, 100 short serial, 101 enhanced serial; 000, 110 and 111 mean none.
REQ-008 SHALL have port clear_cnt_i  in  1  clears crc_err_cnt_o.
REQ-009 SHALL have port busy_o  out  1  CRC computation in progress.
REQ-010 SHALL have port crc_valid_o  out  1  one-cycle result strobe.
REQ-011 SHALL have port crc_ok_o  out  1  received CRC equals calculated CRC; valid with crc_valid_o.
REQ-012 SHALL have port msg_type_o  out  3  captured done_pre_data_i code.
REQ-013 SHALL have port data_o  out  24  checked payload, right-justified, zero-filled.
REQ-014 SHALL have port crc_rx_o / crc_calc_o  out  6 each  received and calculated CRC, right-justified.
REQ-015 SHALL have port crc_err_cnt_o  out  ERR_CNT_W  saturating mismatch count.
REQ-016 SHALL have port overrun_o  out  1  one-cycle pulse when a strobe is dropped.

Function
REQ-017 Field map SHALL be: 001 payload [27:4], CRC4 [3:0]; 010 payload [19:4], CRC4 [3:0]; 011 and 100 payload [15:4], CRC4 [3:0]; 101 payload [29:6], CRC6 [5:0].
REQ-018 The CRC4 calculation SHALL use polynomial x^4+x^3+x^2+1 and preload CRC4_SEED.
REQ-019 The CRC6 calculation SHALL use polynomial x^6+x^4+x^3+1 and preload CRC6_SEED.
REQ-020 The engine SHALL be bit-serial, one bit per clk_rx, MSB first, per step: fb=crc[msb]; crc={crc[msb-1:0],bit}; XOR poly low bits if fb.
REQ-021 The payload SHALL be followed by width-many zero bits (augmentation), so N = 28/20/16/16/30 shift cycles for types 001/010/011/100/101.
REQ-022 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-023 IDLE or DONE with a valid strobe SHALL capture the input fields, load the seed and bit counter, and go to SHIFT.
REQ-024 SHIFT SHALL go to DONE after N bits.
REQ-025 DONE SHALL return to IDLE when no strobe is present.
REQ-026 crc_valid_o SHALL be high exactly N+1 cycles after the strobe cycle, for one cycle only (the DONE cycle).
REQ-027 crc_ok_o, crc_calc_o, crc_rx_o, data_o and msg_type_o SHALL be registered and SHALL hold until the next result.
REQ-028 busy_o SHALL be high throughout SHIFT only.
REQ-029 A valid strobe during SHIFT SHALL be dropped, SHALL pulse overrun_o the next cycle, and SHALL leave the computation in progress unaffected.
REQ-030 A strobe in the DONE cycle SHALL be accepted with no gap (back-to-back).
REQ-031 Codes 000, 110 and 111 SHALL be ignored in every state, with no overrun.
REQ-032 crc_err_cnt_o SHALL increment by one on each crc_valid_o cycle with crc_ok_o=0.
REQ-033 crc_err_cnt_o SHALL saturate at all-ones.
REQ-034 clear_cnt_i SHALL zero crc_err_cnt_o next cycle and SHALL take priority over a coincident increment.
REQ-035 CRC4 results SHALL be zero-extended into bits [5:4] of crc_rx_o and crc_calc_o.

Reset
REQ-036 reset_rx SHALL force state IDLE and zero every output and internal register, including mid-SHIFT.
REQ-037 A strobe coincident with reset_rx SHALL be discarded.
REQ-038 The first strobe SHALL be accepted on the cycle after reset_rx deasserts.

Verification
REQ-039 Type 001, data 30'h0000005 -> crc_valid_o at strobe+29; crc_ok_o=1; crc_calc_o=6'h05; err count unchanged.
REQ-040 Type 001, data 30'h0000004 -> crc_ok_o=0; crc_rx_o=6'h04; crc_calc_o=6'h05; crc_err_cnt_o +1.
REQ-041 Types 011 data 30'h9, 010 data 30'hC and 101 data 30'h26, each back-to-back on its DONE cycle -> three crc_ok_o=1 results, no overrun_o, crc_calc_o 6'h09/6'h0C/6'h26.
REQ-042 Type 100 strobe, then type 001 strobe 5 cycles later -> overrun_o pulse; the single result is for type 100.
REQ-043 300 consecutive mismatches -> crc_err_cnt_o=8'hFF; clear_cnt_i coincident with a mismatch -> 0.
REQ-044 reset_rx mid-SHIFT -> no crc_valid_o; all outputs 0; the next strobe completes normally.
